// File: rtl/multdiv_sequencer.sv
// Execute-stage iterative signed multiply/divide with decode stall outputs.
// One shift-add or restoring-divide step per cycle on operand magnitudes.
module multdiv_sequencer #(
  parameter int unsigned ITERATIONS   = 32,
  parameter int unsigned RSTATUS_REG  = 30,
  parameter int unsigned RSTATUS_MULT = 4,
  parameter int unsigned RSTATUS_DIV  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] d_x_instructions_input,
  input  logic [31:0] operand_A,
  input  logic [31:0] operand_B,
  output logic        mult_operation_underway,
  output logic        div_operation_underway,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        exception
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [5:0] LAST = 6'(ITERATIONS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_opnd;
  logic [63:0] r_acc;
  logic        r_neg;
  logic        r_isdiv;
  logic [4:0]  r_dst;
  logic        r_valid;
  logic [31:0] r_result;
  logic [4:0]  r_rd;
  logic        r_exc;

  logic        w_opc0;
  logic        w_mult;
  logic        w_div;
  logic        w_start;
  logic        w_div0;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_sum;
  logic [32:0] w_trial;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_prod_s;
  logic [31:0] w_quo;
  logic        w_ovf;

  assign w_opc0  = d_x_instructions_input[31:27] == 5'b00000;
  assign w_mult  = w_opc0 && d_x_instructions_input[6:2] == 5'b00110;
  assign w_div   = w_opc0 && d_x_instructions_input[6:2] == 5'b00111;
  assign w_start = (w_mult || w_div) && r_state != S_RUN;
  assign w_div0  = w_div && operand_B == 32'd0;

  assign w_abs_a = operand_A[31] ? -operand_A : operand_A;
  assign w_abs_b = operand_B[31] ? -operand_B : operand_B;

  // mult: acc = {partial hi, multiplier}; div: acc = {remainder, quotient}
  assign w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_trial = r_acc[63:31] - {1'b0, r_opnd};

  always_comb begin
    w_acc_nxt = r_acc;
    if (!r_isdiv)
      w_acc_nxt = {w_sum, r_acc[31:1]};
    else if (!w_trial[32])
      w_acc_nxt = {w_trial[31:0], r_acc[30:0], 1'b1};
    else
      w_acc_nxt = {r_acc[62:0], 1'b0};
  end

  assign w_prod_s = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quo    = r_neg ? -w_acc_nxt[31:0] : w_acc_nxt[31:0];
  assign w_ovf    = w_prod_s[63:32] != {32{w_prod_s[31]}};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:   w_state_nxt = (r_cnt == LAST) ? S_DONE : S_RUN;
      default: begin
        if (w_start)
          w_state_nxt = w_div0 ? S_DONE : S_RUN;
        else
          w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mult_operation_underway =
    (w_start && w_mult) || (r_state == S_RUN && !r_isdiv);
  assign div_operation_underway  =
    (w_start && w_div) || (r_state == S_RUN && r_isdiv);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_opnd   <= 32'd0;
      r_acc    <= 64'd0;
      r_neg    <= 1'b0;
      r_isdiv  <= 1'b0;
      r_dst    <= 5'd0;
      r_valid  <= 1'b0;
      r_result <= 32'd0;
      r_rd     <= 5'd0;
      r_exc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      if (r_state == S_RUN) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 6'd1;
        if (r_cnt == LAST) begin
          r_valid <= 1'b1;
          if (!r_isdiv && w_ovf) begin
            r_exc    <= 1'b1;
            r_rd     <= 5'(RSTATUS_REG);
            r_result <= 32'(RSTATUS_MULT);
          end else begin
            r_exc    <= 1'b0;
            r_rd     <= r_dst;
            r_result <= r_isdiv ? w_quo : w_prod_s[31:0];
          end
        end
      end else if (w_start) begin
        r_cnt   <= 6'd0;
        r_isdiv <= w_div;
        r_neg   <= operand_A[31] ^ operand_B[31];
        r_dst   <= d_x_instructions_input[26:22];
        r_opnd  <= w_div ? w_abs_b : w_abs_a;
        r_acc   <= {32'd0, w_div ? w_abs_a : w_abs_b};
        if (w_div0) begin
          r_valid  <= 1'b1;
          r_exc    <= 1'b1;
          r_rd     <= 5'(RSTATUS_REG);
          r_result <= 32'(RSTATUS_DIV);
        end
      end
    end
  end

  assign result_valid = r_valid;
  assign result       = r_result;
  assign result_rd    = r_rd;
  assign exception    = r_exc;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed vector bench for multdiv_sequencer: latency, stalls, results.
// Table-driven single ops plus reset-abort and back-to-back sequences.
module tb_multdiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        mult_uw;
  logic        div_uw;
  logic        rvalid;
  logic [31:0] res;
  logic [4:0]  res_rd;
  logic        exc;

  int pass_cnt = 0;
  int total    = 0;

  multdiv_sequencer dut (
    .clock                  (clk),
    .reset                  (rst_n),
    .d_x_instructions_input (instr),
    .operand_A              (opa),
    .operand_B              (opb),
    .mult_operation_underway(mult_uw),
    .div_operation_underway (div_uw),
    .result_valid           (rvalid),
    .result                 (res),
    .result_rd              (res_rd),
    .exception              (exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dv;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic [4:0]  erd;
    bit          eexc;
    int          lat;
  } vec_t;

  vec_t v[12];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] enc(input bit dv, input logic [4:0] rd);
    logic [4:0] alu;
    alu = dv ? 5'b00111 : 5'b00110;
    return {5'b00000, rd, 15'd0, alu, 2'b00};
  endfunction

  // Called at a negedge: check cycle-0 stall, cross the acceptance edge.
  task automatic present(input bit dv, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
    instr = enc(dv, rd);
    opa   = a;
    opb   = b;
    #1;
    chk("uw0_mult", {31'd0, mult_uw}, {31'd0, !dv});
    chk("uw0_div",  {31'd0, div_uw},  {31'd0, dv});
    @(posedge clk);
    #1;
    instr = 32'd0;
    opa   = 32'd0;
    opb   = 32'd0;
  endtask

  // Returns at the negedge inside the DONE cycle.
  task automatic await(input string tag, input bit dv, input int lat,
                       input logic [31:0] er, input logic [4:0] erd,
                       input bit eexc);
    int cyc;
    bit stall_ok;
    stall_ok = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      cyc = i;
      if (rvalid) break;
      if (mult_uw !== !dv || div_uw !== dv) stall_ok = 1'b0;
    end
    if (!rvalid) cyc = 99;
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
    chk({tag, "_res"}, res, er);
    chk({tag, "_rd"}, {27'd0, res_rd}, {27'd0, erd});
    chk({tag, "_exc"}, {31'd0, exc}, {31'd0, eexc});
    chk({tag, "_uwdone"}, {30'd0, mult_uw, div_uw}, 32'd0);
  endtask

  initial begin
    bit seen;
    v[0]  = '{0, 5'd3,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 5'd3,  0, 33};
    v[1]  = '{0, 5'd4,  32'h00010000, 32'h00010000, 32'd4,        5'd30, 1, 33};
    v[2]  = '{1, 5'd5,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 5'd5,  0, 33};
    v[3]  = '{1, 5'd6,  32'd5,        32'd0,        32'd5,        5'd30, 1, 1};
    v[4]  = '{0, 5'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        5'd8,  0, 33};
    v[5]  = '{0, 5'd9,  32'h80000000, 32'd1,        32'h80000000, 5'd9,  0, 33};
    v[6]  = '{0, 5'd10, 32'h80000000, 32'hFFFFFFFF, 32'd4,        5'd30, 1, 33};
    v[7]  = '{0, 5'd11, 32'h40000000, 32'd2,        32'd4,        5'd30, 1, 33};
    v[8]  = '{1, 5'd12, 32'd100,      32'd7,        32'd14,       5'd12, 0, 33};
    v[9]  = '{1, 5'd13, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       5'd13, 0, 33};
    v[10] = '{1, 5'd14, 32'd7,        32'hFFFFFF9C, 32'd0,        5'd14, 0, 33};
    v[11] = '{0, 5'd0,  32'd6,        32'd7,        32'd42,       5'd0,  0, 33};

    rst_n = 1'b0;
    instr = 32'd0;
    opa   = 32'd0;
    opb   = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, rvalid}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_rd", {27'd0, res_rd}, 32'd0);
    chk("rst_exc", {31'd0, exc}, 32'd0);
    chk("rst_uw", {30'd0, mult_uw, div_uw}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      present(v[k].dv, v[k].rd, v[k].a, v[k].b);
      await($sformatf("v%0d", k), v[k].dv, v[k].lat, v[k].er, v[k].erd,
            v[k].eexc);
      @(negedge clk);
    end

    // Abort a multiply with reset at the cycle-10 edge.
    present(0, 5'd2, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_uw", {30'd0, mult_uw, div_uw}, 32'd0);
    chk("abort_res", res, 32'd0);
    chk("abort_rd", {27'd0, res_rd}, 32'd0);
    chk("abort_exc", {31'd0, exc}, 32'd0);
    seen = 1'b0;
    for (int i = 11; i <= 40; i++) begin
      @(negedge clk);
      if (rvalid || mult_uw || div_uw) seen = 1'b1;
    end
    chk("abort_quiet", {31'd0, seen}, 32'd0);

    // Back-to-back: divide presented during the multiply's DONE cycle.
    present(0, 5'd7, 32'd3, 32'd5);
    await("b2b_m", 0, 33, 32'd15, 5'd7, 0);
    instr = enc(1, 5'd15);
    opa   = 32'h80000000;
    opb   = 32'hFFFFFFFF;
    #1;
    chk("b2b_uwdiv", {31'd0, div_uw}, 32'd1);
    chk("b2b_uwmult", {31'd0, mult_uw}, 32'd0);
    @(posedge clk);
    #1;
    instr = 32'd0;
    opa   = 32'd0;
    opb   = 32'd0;
    await("b2b_d", 1, 33, 32'h80000000, 5'd15, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
